// File: rtl/time_set_controller_if.sv
// ---------------------------------------------------------------------------
// time_set_controller_if
// Purpose : bundles the button/tick inputs and the set/advance/mode outputs
//           of the time-set mode sequencer so they can be passed as one port.
// Signals :
//   tick      1  one-cycle 1 Hz strobe (clkmain domain)
//   btn_mode  1  raw mode button level, asynchronous
//   btn_inc   1  raw increment button level, asynchronous
//   set_sec   1  set-time level to seconds group
//   set_min   1  set-time level to minutes group
//   set_hr    1  set-time level to hours group
//   adv_sec   1  one-cycle advance strobe to seconds group
//   adv_min   1  one-cycle advance strobe to minutes group
//   adv_hr    1  one-cycle advance strobe to hours group
//   mode      2  current state: 00 RUN, 01 SET_SEC, 10 SET_MIN, 11 SET_HR
//   blink     1  display blink for the group being set
// Modports: master drives buttons/tick and observes outputs; slave is the
//           controller itself.
// ---------------------------------------------------------------------------
interface time_set_controller_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       set_sec;
    logic       set_min;
    logic       set_hr;
    logic       adv_sec;
    logic       adv_min;
    logic       adv_hr;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output tick, btn_mode, btn_inc,
        input  set_sec, set_min, set_hr, adv_sec, adv_min, adv_hr, mode, blink
    );

    modport slave (
        input  tick, btn_mode, btn_inc,
        output set_sec, set_min, set_hr, adv_sec, adv_min, adv_hr, mode, blink
    );
endinterface

// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
// Purpose : mode sequencer for the digital-clock digit chain. Cycles through
//           RUN -> SET_SEC -> SET_MIN -> SET_HR -> RUN on mode presses, emits
//           one-cycle advance strobes to the group being set on inc presses,
//           forwards the 1 Hz tick to the seconds group while running, and
//           falls back to RUN after TIMEOUT_TICKS idle ticks in a SET state.
// Ports   :
//   clkmain  in  main clock, all logic on posedge
//   clear_n  in  synchronous active-low reset
//   bus      time_set_controller_if.slave (tick, buttons, set/adv/mode/blink)
// Parameters:
//   TIMEOUT_TICKS  idle ticks in a SET state before returning to RUN (1..255)
//   REPEAT_START   cycles btn_inc must be held before auto-repeat starts
//   REPEAT_RATE    cycles between auto-repeat strobes
// Configuration:
//   AUTO_REPEAT_EN  when defined, holding btn_inc in a SET state produces
//                   repeated advance strobes; otherwise one strobe per press.
// All outputs are registered.
// ---------------------------------------------------------------------------
module time_set_controller #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int REPEAT_START  = 500,
    parameter int REPEAT_RATE   = 100
) (
    input  logic                        clkmain,
    input  logic                        clear_n,
    time_set_controller_if.slave        bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_SEC = 2'b01,
        SET_MIN = 2'b10,
        SET_HR  = 2'b11
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_TICKS);

    state_t     state;
    state_t     next_state;
    logic       state_change;
    logic       timeout_hit;
    logic       inc_fire;
    logic       repeat_fire;
    logic [7:0] timeout_cnt;

    logic       mode_sync1, mode_sync2, mode_last, mode_press;
    logic       inc_sync1,  inc_sync2,  inc_last,  inc_press;

    logic       set_sec_r, set_min_r, set_hr_r;
    logic       adv_sec_r, adv_min_r, adv_hr_r;
    logic       blink_r;

    // Synchronisers and edge registers reset to 1 so a button already held
    // during reset is seen as "still high" and never produces a press.
    // The press pulse is registered, which puts the FSM reaction three edges
    // after the raw rise is first sampled.
    always_ff @(posedge clkmain) begin
        if (!clear_n) begin
            mode_sync1 <= 1'b1;
            mode_sync2 <= 1'b1;
            mode_last  <= 1'b1;
            mode_press <= 1'b0;
            inc_sync1  <= 1'b1;
            inc_sync2  <= 1'b1;
            inc_last   <= 1'b1;
            inc_press  <= 1'b0;
        end else begin
            mode_sync1 <= bus.btn_mode;
            mode_sync2 <= mode_sync1;
            mode_last  <= mode_sync2;
            mode_press <= mode_sync2 & ~mode_last;
            inc_sync1  <= bus.btn_inc;
            inc_sync2  <= inc_sync1;
            inc_last   <= inc_sync2;
            inc_press  <= inc_sync2 & ~inc_last;
        end
    end

    assign timeout_hit = (state != RUN) && (timeout_cnt == TIMEOUT_LIM);

    // A mode press always wins over a coincident timeout, so the timeout only
    // forces RUN when no mode press is pending. The 2-bit increment wraps
    // SET_HR back to RUN.
    always_comb begin
        next_state = state;
        if (mode_press) begin
            next_state = state_t'(state + 2'd1);
        end else if (timeout_hit) begin
            next_state = RUN;
        end
    end

    assign state_change = (next_state != state);

    // Advance strobes are suppressed whenever the state is about to change,
    // so an inc press coinciding with a mode press or timeout is dropped.
    assign inc_fire = (state != RUN) && !state_change && (inc_press || repeat_fire);

`ifdef AUTO_REPEAT_EN
    logic [15:0] rep_cnt;
    logic        rep_armed;
    logic        rep_first;
    logic [15:0] rep_target;

    assign rep_target  = rep_first ? 16'(REPEAT_START) : 16'(REPEAT_RATE);
    assign repeat_fire = rep_armed && inc_sync2 && !inc_press &&
                         ((rep_cnt + 16'd1) == rep_target);

    // rep_cnt counts cycles since the last strobe (press or repeat). The first
    // gap is REPEAT_START, later gaps REPEAT_RATE. Release, RUN or any state
    // change disarms and clears the counter.
    always_ff @(posedge clkmain) begin
        if (!clear_n) begin
            rep_cnt   <= 16'd0;
            rep_armed <= 1'b0;
            rep_first <= 1'b1;
        end else if (state_change || (state == RUN) || !inc_sync2) begin
            rep_cnt   <= 16'd0;
            rep_armed <= 1'b0;
            rep_first <= 1'b1;
        end else if (inc_press) begin
            rep_cnt   <= 16'd0;
            rep_armed <= 1'b1;
            rep_first <= 1'b1;
        end else if (rep_armed) begin
            if (repeat_fire) begin
                rep_cnt   <= 16'd0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 16'd1;
            end
        end
    end
`else
    logic repeat_params_unused;

    assign repeat_fire          = 1'b0;
    assign repeat_params_unused = (REPEAT_START != 0) ^ (REPEAT_RATE != 0);
`endif

    // Main FSM with registered outputs. set_* follow next_state so they change
    // on the same edge as mode. The timeout counter and blink are held at 0
    // in RUN and cleared on every state change; any press or repeat strobe
    // clears the timeout and swallows a coincident tick.
    always_ff @(posedge clkmain) begin
        if (!clear_n) begin
            state       <= RUN;
            timeout_cnt <= 8'd0;
            set_sec_r   <= 1'b0;
            set_min_r   <= 1'b0;
            set_hr_r    <= 1'b0;
            adv_sec_r   <= 1'b0;
            adv_min_r   <= 1'b0;
            adv_hr_r    <= 1'b0;
            blink_r     <= 1'b0;
        end else begin
            state     <= next_state;
            set_sec_r <= (next_state == SET_SEC);
            set_min_r <= (next_state == SET_MIN);
            set_hr_r  <= (next_state == SET_HR);

            adv_sec_r <= ((state == RUN) && !state_change && bus.tick) ||
                         ((state == SET_SEC) && inc_fire);
            adv_min_r <= (state == SET_MIN) && inc_fire;
            adv_hr_r  <= (state == SET_HR)  && inc_fire;

            if (state_change || (next_state == RUN)) begin
                timeout_cnt <= 8'd0;
            end else if (mode_press || inc_press || repeat_fire) begin
                timeout_cnt <= 8'd0;
            end else if (bus.tick) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end

            if (state_change || (next_state == RUN)) begin
                blink_r <= 1'b0;
            end else if (bus.tick) begin
                blink_r <= ~blink_r;
            end
        end
    end

    assign bus.mode    = state;
    assign bus.set_sec = set_sec_r;
    assign bus.set_min = set_min_r;
    assign bus.set_hr  = set_hr_r;
    assign bus.adv_sec = adv_sec_r;
    assign bus.adv_min = adv_min_r;
    assign bus.adv_hr  = adv_hr_r;
    assign bus.blink   = blink_r;

endmodule

// File: tb/tb_time_set_controller.sv
// ---------------------------------------------------------------------------
// tb_time_set_controller
// Self-checking bench for time_set_controller. Expected advance strobes are
// queued with the cycle they must appear on; a negedge monitor pops and
// compares every strobe the DUT emits. Scenario tasks check mode/set/blink
// inline. Honours AUTO_REPEAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_time_set_controller;

    typedef struct {
        int         cyc;
        logic [2:0] adv;
    } exp_t;

    logic clkmain;
    logic clear_n;
    int   cyc;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    time_set_controller_if bus ();

    time_set_controller #(
        .TIMEOUT_TICKS (10),
        .REPEAT_START  (500),
        .REPEAT_RATE   (100)
    ) dut (
        .clkmain (clkmain),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clkmain = 1'b0;
    always #5 clkmain = ~clkmain;

    initial cyc = 0;
    always @(posedge clkmain) cyc <= cyc + 1;

    // Every strobe seen must match the head of the expectation queue.
    always @(negedge clkmain) begin
        logic [2:0] seen;
        exp_t       e;
        seen = {bus.adv_hr, bus.adv_min, bus.adv_sec};
        if (seen != 3'b000) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_strobe cycle %0d adv=%b, required none", cyc, seen);
            end else begin
                e = sb.pop_front();
                if (e.cyc !== cyc || e.adv !== seen) begin
                    tests_failed++;
                    $display("[TB] FAIL strobe got cycle %0d adv=%b, required cycle %0d adv=%b",
                             cyc, seen, e.cyc, e.adv);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clkmain);
    endtask

    task automatic push_exp(input int c, input logic [2:0] a);
        exp_t e;
        e.cyc = c;
        e.adv = a;
        sb.push_back(e);
    endtask

    // Drives a one-cycle tick; returns at the negedge right after the edge
    // that sampled it.
    task automatic pulse_tick();
        bus.tick = 1'b1;
        @(negedge clkmain);
        bus.tick = 1'b0;
    endtask

    task automatic press_mode_plain();
        bus.btn_mode = 1'b1;
        wait_cycles(4);
        bus.btn_mode = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_reset();
        clear_n      = 1'b0;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b0;
        bus.tick     = 1'b0;
        wait_cycles(3);
        tests_run++;
        if ({bus.mode, bus.set_hr, bus.set_min, bus.set_sec, bus.blink} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got mode=%b set=%b%b%b blink=%b, required all 0",
                     bus.mode, bus.set_hr, bus.set_min, bus.set_sec, bus.blink);
        end
        tests_run++;
        if ({bus.adv_hr, bus.adv_min, bus.adv_sec} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_adv got %b, required 000",
                     {bus.adv_hr, bus.adv_min, bus.adv_sec});
        end
        clear_n = 1'b1;
        wait_cycles(10);
        tests_run++;
        if (bus.mode !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL held_mode_after_reset got %b, required 00", bus.mode);
        end
        bus.btn_mode = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_run_tick();
        for (int i = 0; i < 5; i++) begin
            push_exp(cyc + 1, 3'b001);
            pulse_tick();
            wait_cycles(19);
            tests_run++;
            if ({bus.set_hr, bus.set_min, bus.set_sec} !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL run_set_levels got %b, required 000",
                         {bus.set_hr, bus.set_min, bus.set_sec});
            end
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL run_ticks_missing got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode;
        logic [2:0] exp_set;
        for (int p = 1; p <= 4; p++) begin
            exp_mode = 2'(p);
            exp_set  = {exp_mode == 2'b11, exp_mode == 2'b10, exp_mode == 2'b01};
            bus.btn_mode = 1'b1;
            wait_cycles(3);
            tests_run++;
            if (bus.mode !== 2'(p - 1)) begin
                tests_failed++;
                $display("[TB] FAIL mode_early_%0d got %b, required %b", p, bus.mode, 2'(p - 1));
            end
            wait_cycles(1);
            tests_run++;
            if (bus.mode !== exp_mode ||
                {bus.set_hr, bus.set_min, bus.set_sec} !== exp_set) begin
                tests_failed++;
                $display("[TB] FAIL mode_press_%0d got mode=%b set=%b, required mode=%b set=%b",
                         p, bus.mode, {bus.set_hr, bus.set_min, bus.set_sec}, exp_mode, exp_set);
            end
            bus.btn_mode = 1'b0;
            wait_cycles(4);
            if (exp_mode == 2'b10) begin
                for (int k = 0; k < 3; k++) begin
                    bus.btn_inc = 1'b1;
                    push_exp(cyc + 4, 3'b010);
                    wait_cycles(4);
                    bus.btn_inc = 1'b0;
                    wait_cycles(4);
                end
                tests_run++;
                if (sb.size() != 0) begin
                    tests_failed++;
                    $display("[TB] FAIL set_min_inc got %0d pending, required 0", sb.size());
                end
            end
        end
    endtask

    task automatic test_timeout();
        press_mode_plain();
        tests_run++;
        if (bus.mode !== 2'b01 || bus.blink !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL enter_set_sec got mode=%b blink=%b, required 01 0", bus.mode, bus.blink);
        end
        for (int t = 1; t <= 10; t++) begin
            pulse_tick();
            if (t <= 2) begin
                tests_run++;
                if (bus.blink !== 1'(t % 2)) begin
                    tests_failed++;
                    $display("[TB] FAIL blink_tick_%0d got %b, required %b", t, bus.blink, 1'(t % 2));
                end
            end
            if (t == 10) begin
                tests_run++;
                if (bus.mode !== 2'b01) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_early got %b, required 01", bus.mode);
                end
                wait_cycles(1);
                tests_run++;
                if (bus.mode !== 2'b00 || bus.set_sec !== 1'b0 || bus.blink !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_return got mode=%b set_sec=%b blink=%b, required 00 0 0",
                             bus.mode, bus.set_sec, bus.blink);
                end
            end else begin
                wait_cycles(4);
            end
        end
        wait_cycles(4);

        // Restart: 8 ticks, then an inc press whose consuming edge also sees a tick.
        press_mode_plain();
        for (int t = 0; t < 8; t++) begin
            pulse_tick();
            wait_cycles(4);
        end
        bus.btn_inc = 1'b1;
        push_exp(cyc + 4, 3'b001);
        wait_cycles(3);
        pulse_tick();
        bus.btn_inc = 1'b0;
        wait_cycles(4);
        for (int t = 1; t <= 10; t++) begin
            pulse_tick();
            if (t == 9) begin
                wait_cycles(1);
                tests_run++;
                if (bus.mode !== 2'b01) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_restart_9 got %b, required 01", bus.mode);
                end
                wait_cycles(3);
            end else if (t == 10) begin
                wait_cycles(1);
                tests_run++;
                if (bus.mode !== 2'b00) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_restart_10 got %b, required 00", bus.mode);
                end
            end else begin
                wait_cycles(4);
            end
        end
        wait_cycles(4);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_inc_strobe got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_simultaneous();
        press_mode_plain();
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        wait_cycles(4);
        tests_run++;
        if (bus.mode !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL mode_inc_same got mode=%b, required 10", bus.mode);
        end
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        wait_cycles(4);
        press_mode_plain();
        tests_run++;
        if (bus.mode !== 2'b11 || bus.set_hr !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL enter_set_hr got mode=%b set_hr=%b, required 11 1", bus.mode, bus.set_hr);
        end
        clear_n = 1'b0;
        wait_cycles(1);
        tests_run++;
        if ({bus.mode, bus.set_hr, bus.set_min, bus.set_sec, bus.blink,
             bus.adv_hr, bus.adv_min, bus.adv_sec} !== 9'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_set_reset got mode=%b set=%b%b%b, required all 0",
                     bus.mode, bus.set_hr, bus.set_min, bus.set_sec);
        end
        clear_n = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_auto_repeat();
        int c0;
        for (int p = 0; p < 3; p++) press_mode_plain();
        tests_run++;
        if (bus.mode !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL repeat_setup got %b, required 11", bus.mode);
        end
        c0 = cyc;
        bus.btn_inc = 1'b1;
        push_exp(c0 + 4, 3'b100);
`ifdef AUTO_REPEAT_EN
        push_exp(c0 + 504, 3'b100);
        push_exp(c0 + 604, 3'b100);
        push_exp(c0 + 704, 3'b100);
`endif
        wait_cycles(800);
        bus.btn_inc = 1'b0;
        wait_cycles(10);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL repeat_strobes got %0d pending, required 0", sb.size());
        end
        press_mode_plain();
        tests_run++;
        if (bus.mode !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL wrap_to_run got %b, required 00", bus.mode);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_run_tick();
        test_mode_cycle();
        test_timeout();
        test_simultaneous();
        test_auto_repeat();
        wait_cycles(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
